// File: rtl/rgmii_pkg.sv
// Shared constants, state encoding and helpers for the RGMII receive packager.
package rgmii_pkg;

    localparam int unsigned PREAMBLE_CNT_W = 8;
    localparam int unsigned BYTE_CNT_W     = 16;
    localparam int unsigned CRC_W          = 32;

    localparam logic [1:0] SPEED_CODE_GIGABIT     = 2'd2;
    localparam logic [1:0] SPEED_CODE_100_MEGABIT = 2'd1;
    localparam logic [1:0] SPEED_CODE_10_MEGABIT  = 2'd0;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_GIGABIT   = 8'hD5;
    localparam logic [7:0] SFD_NIBBLE    = 8'hDD;

    // CRC-32 (0x04C11DB7) processed LSB first, so the register uses the reflected polynomial.
    localparam logic [CRC_W-1:0] CRC_POLY_REFLECTED = 32'hEDB88320;
    localparam logic [CRC_W-1:0] CRC_INIT           = 32'hFFFFFFFF;
    localparam logic [CRC_W-1:0] CRC_RESIDUE        = 32'hC704DD7B;

    typedef enum logic [2:0] {
        S_SYNC,
        S_BYTE,
        S_NIBBLE_LO,
        S_NIBBLE_HI,
        S_DROP
    } state_type;

    // Bit-reverse a CRC register so it can be compared against the MSB-first residue.
    function automatic logic [CRC_W-1:0] reverse32(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(CRC_W); i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rgmii_crc32_byte.sv
// Combinational CRC-32 update of a reflected register by one byte.
module rgmii_crc32_byte
    import rgmii_pkg::*;
(
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       data_in,
    output logic [CRC_W-1:0] crc_out_c
);

    // Eight LSB-first shift/xor steps.
    always_comb begin
        crc_out_c = crc_in ^ {24'd0, data_in};
        for (int i = 0; i < 8; i++) begin
            crc_out_c = crc_out_c[0] ? ((crc_out_c >> 1) ^ CRC_POLY_REFLECTED) : (crc_out_c >> 1);
        end
    end

endmodule

// File: rtl/rgmii_frame_packager.sv
// RGMII receive packager: preamble/SFD lock, byte/nibble mode detect, nibble
// reassembly, first/last marking and per-frame error status.
// Optional FCS check enabled by defining RGMII_FRAME_PACKAGER_FCS_CHECK_EN.
module rgmii_frame_packager
    import rgmii_pkg::*;
#(
    parameter int unsigned PREAMBLE_MIN_BYTES = 6,
    parameter int unsigned MAX_FRAME_BYTES    = 1522
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       data_enable,
    input  logic       data_error,
    input  logic       link_is_10_megabit,
    output logic [8:0] packaged_data,
    output logic       packaged_data_valid,
    output logic       packaged_data_last,
    output logic       frame_error,
    output logic [1:0] speed_code
);

    localparam logic [PREAMBLE_CNT_W-1:0] PREAMBLE_MIN = PREAMBLE_CNT_W'(PREAMBLE_MIN_BYTES);
    localparam logic [BYTE_CNT_W-1:0]     MAX_BYTES    = BYTE_CNT_W'(MAX_FRAME_BYTES);

    logic [7:0]                in_data_q, in_data_d;
    logic                      in_enable_q, in_enable_d;
    logic                      in_error_q, in_error_d;
    state_type                 state_q, state_d;
    logic [PREAMBLE_CNT_W-1:0] preamble_cnt_q, preamble_cnt_d;
    logic [BYTE_CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [3:0]                lo_nibble_q, lo_nibble_d;
    logic [7:0]                pend_byte_q, pend_byte_d;
    logic                      pend_valid_q, pend_valid_d;
    logic                      pend_first_q, pend_first_d;
    logic                      sticky_err_q, sticky_err_d;
    logic [1:0]                speed_q, speed_d;
    logic [8:0]                out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic                      out_err_q, out_err_d;

    logic       in_frame;
    logic       frame_start;
    logic       frame_end;
    logic       odd_nibble;
    logic       new_byte_vld;
    logic [7:0] new_byte;
    logic       byte_accept;
    logic       fcs_bad;

    // Next-state, pending-byte and output computation.
    always_comb begin
        in_data_d      = data;
        in_enable_d    = data_enable;
        in_error_d     = data_error;
        state_d        = state_q;
        preamble_cnt_d = preamble_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        lo_nibble_d    = lo_nibble_q;
        pend_byte_d    = pend_byte_q;
        pend_valid_d   = pend_valid_q;
        pend_first_d   = pend_first_q;
        sticky_err_d   = sticky_err_q;
        speed_d        = speed_q;
        out_data_d     = out_data_q;
        out_valid_d    = 1'b0;
        out_last_d     = 1'b0;
        out_err_d      = 1'b0;
        frame_start    = 1'b0;
        frame_end      = 1'b0;
        odd_nibble     = 1'b0;
        new_byte_vld   = 1'b0;
        new_byte       = '0;
        byte_accept    = 1'b0;
        in_frame       = state_q inside {S_BYTE, S_NIBBLE_LO, S_NIBBLE_HI};

        case (state_q)
            S_SYNC: begin
                if (in_enable_q && !in_error_q && in_data_q == PREAMBLE_BYTE) begin
                    if (preamble_cnt_q != '1) begin
                        preamble_cnt_d = preamble_cnt_q + PREAMBLE_CNT_W'(1);
                    end
                end else begin
                    preamble_cnt_d = '0;
                    if (in_enable_q && !in_error_q && preamble_cnt_q >= PREAMBLE_MIN) begin
                        if (in_data_q == SFD_GIGABIT) begin
                            state_d     = S_BYTE;
                            speed_d     = SPEED_CODE_GIGABIT;
                            frame_start = 1'b1;
                        end else if (in_data_q == SFD_NIBBLE) begin
                            state_d     = S_NIBBLE_LO;
                            speed_d     = link_is_10_megabit ? SPEED_CODE_10_MEGABIT
                                                             : SPEED_CODE_100_MEGABIT;
                            frame_start = 1'b1;
                        end
                    end
                end
            end
            S_BYTE: begin
                if (!in_enable_q) begin
                    frame_end = 1'b1;
                end else begin
                    new_byte_vld = 1'b1;
                    new_byte     = in_data_q;
                end
            end
            S_NIBBLE_LO: begin
                if (!in_enable_q) begin
                    frame_end = 1'b1;
                end else begin
                    lo_nibble_d = in_data_q[3:0];
                    state_d     = S_NIBBLE_HI;
                end
            end
            S_NIBBLE_HI: begin
                if (!in_enable_q) begin
                    frame_end  = 1'b1;
                    odd_nibble = 1'b1;
                end else begin
                    new_byte_vld = 1'b1;
                    new_byte     = {in_data_q[3:0], lo_nibble_q};
                    state_d      = S_NIBBLE_LO;
                end
            end
            S_DROP: begin
                if (!in_enable_q) begin
                    state_d = S_SYNC;
                end
            end
            default: state_d = S_SYNC;
        endcase

        if (in_frame && in_enable_q && in_error_q) begin
            sticky_err_d = 1'b1;
        end

        // A new byte either pushes the pending byte out, or overflows the frame.
        if (new_byte_vld) begin
            if (byte_cnt_q >= MAX_BYTES) begin
                out_valid_d  = pend_valid_q;
                out_data_d   = {pend_first_q, pend_byte_q};
                out_last_d   = pend_valid_q;
                out_err_d    = pend_valid_q;
                pend_valid_d = 1'b0;
                state_d      = S_DROP;
            end else begin
                byte_accept  = 1'b1;
                out_valid_d  = pend_valid_q;
                if (pend_valid_q) begin
                    out_data_d = {pend_first_q, pend_byte_q};
                end
                pend_byte_d  = new_byte;
                pend_valid_d = 1'b1;
                pend_first_d = !pend_valid_q;
                if (byte_cnt_q != '1) begin
                    byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                end
            end
        end

        // Enable dropped: flush the pending byte as the frame's last.
        if (frame_end) begin
            state_d        = S_SYNC;
            preamble_cnt_d = '0;
            pend_valid_d   = 1'b0;
            if (pend_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = {pend_first_q, pend_byte_q};
                out_last_d  = 1'b1;
                out_err_d   = sticky_err_q | odd_nibble | fcs_bad;
            end
        end

        if (frame_start) begin
            sticky_err_d = 1'b0;
            byte_cnt_d   = '0;
            pend_valid_d = 1'b0;
            pend_first_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            in_data_q      <= '0;
            in_enable_q    <= 1'b0;
            in_error_q     <= 1'b0;
            state_q        <= S_SYNC;
            preamble_cnt_q <= '0;
            byte_cnt_q     <= '0;
            lo_nibble_q    <= '0;
            pend_byte_q    <= '0;
            pend_valid_q   <= 1'b0;
            pend_first_q   <= 1'b0;
            sticky_err_q   <= 1'b0;
            speed_q        <= SPEED_CODE_100_MEGABIT;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_err_q      <= 1'b0;
        end else begin
            in_data_q      <= in_data_d;
            in_enable_q    <= in_enable_d;
            in_error_q     <= in_error_d;
            state_q        <= state_d;
            preamble_cnt_q <= preamble_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            lo_nibble_q    <= lo_nibble_d;
            pend_byte_q    <= pend_byte_d;
            pend_valid_q   <= pend_valid_d;
            pend_first_q   <= pend_first_d;
            sticky_err_q   <= sticky_err_d;
            speed_q        <= speed_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            out_err_q      <= out_err_d;
        end
    end

`ifdef RGMII_FRAME_PACKAGER_FCS_CHECK_EN
    logic [CRC_W-1:0] crc_q, crc_d, crc_next_c;

    rgmii_crc32_byte u_crc (
        .crc_in    (crc_q),
        .data_in   (new_byte),
        .crc_out_c (crc_next_c)
    );

    // Running CRC over every accepted payload byte, FCS included.
    always_comb begin
        crc_d = crc_q;
        if (frame_start) begin
            crc_d = CRC_INIT;
        end else if (byte_accept) begin
            crc_d = crc_next_c;
        end
    end

    // CRC register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign fcs_bad = (byte_cnt_q < BYTE_CNT_W'(4)) || (reverse32(crc_q) != CRC_RESIDUE);
`else
    assign fcs_bad = 1'b0;
`endif

    assign packaged_data       = out_data_q;
    assign packaged_data_valid = out_valid_q;
    assign packaged_data_last  = out_last_q;
    assign frame_error         = out_err_q;
    assign speed_code          = speed_q;

endmodule

// File: tb/tb_rgmii_frame_packager.sv
// Directed bench for rgmii_frame_packager with a frame-level expected-output model.
module tb_rgmii_frame_packager;

    localparam int MAX = 64;
`ifdef RGMII_FRAME_PACKAGER_FCS_CHECK_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [8:0] d;
        logic       last;
        logic       err;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] data;
    logic       data_enable;
    logic       data_error;
    logic       link_is_10_megabit;
    logic [8:0] packaged_data;
    logic       packaged_data_valid;
    logic       packaged_data_last;
    logic       frame_error;
    logic [1:0] speed_code;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_valid = 0;
    int   first_drive_cyc = 0;
    int   low_cyc = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    logic [8:0] first_data = '0;
    logic [8:0] last_data = '0;
    logic       last_err = 1'b0;
    exp_t exp_q[$];
    exp_t e;

    rgmii_frame_packager #(
        .PREAMBLE_MIN_BYTES (6),
        .MAX_FRAME_BYTES    (MAX)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .data                (data),
        .data_enable         (data_enable),
        .data_error          (data_error),
        .link_is_10_megabit  (link_is_10_megabit),
        .packaged_data       (packaged_data),
        .packaged_data_valid (packaged_data_valid),
        .packaged_data_last  (packaged_data_last),
        .frame_error         (frame_error),
        .speed_code          (speed_code)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Standard Ethernet FCS value (complemented reflected CRC-32) over p[0..n-1].
    function automatic logic [31:0] crc_of(input byte_q_t p, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, p[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic bit fcs_bad(input byte_q_t p, input int n);
        logic [31:0] f;
        if (!FCS_EN) return 1'b0;
        if (n < 4) return 1'b1;
        f = crc_of(p, n - 4);
        return f != {p[n-1], p[n-2], p[n-3], p[n-4]};
    endfunction

    // Expected output stream of one received frame: truncation, markers and error.
    task automatic model_frame(input byte_q_t p, input bit err);
        int n;
        bit ef;
        exp_t x;
        n  = (p.size() > MAX) ? MAX : p.size();
        ef = err || (p.size() > MAX) || fcs_bad(p, n);
        for (int i = 0; i < n; i++) begin
            x.d    = {(i == 0), p[i]};
            x.last = (i == n - 1);
            x.err  = (i == n - 1) && ef;
            exp_q.push_back(x);
        end
    endtask

    task automatic drive(input logic en, input logic er, input logic [7:0] d);
        data_enable = en;
        data_error  = er;
        data        = d;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input bit nib, input int npre, input logic [7:0] sfd,
                              input byte_q_t p, input int er_idx, input bit odd);
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, sfd);
        for (int i = 0; i < p.size(); i++) begin
            if (i == 0) first_drive_cyc = cyc;
            if (!nib) begin
                drive(1'b1, (i == er_idx), p[i]);
            end else begin
                drive(1'b1, (i == er_idx), {p[i][3:0], p[i][3:0]});
                drive(1'b1, 1'b0, {p[i][7:4], p[i][7:4]});
            end
        end
        if (odd) drive(1'b1, 1'b0, 8'h77);
        low_cyc = cyc;
        idle(12);
    endtask

    // Compare every valid output against the model queue.
    always @(negedge clock) begin
        if (packaged_data_valid === 1'b1) begin
            n_valid++;
            if (packaged_data[8]) begin
                first_data = packaged_data;
                first_cyc  = cyc;
            end
            if (packaged_data_last) begin
                last_data = packaged_data;
                last_err  = frame_error;
                last_cyc  = cyc;
            end
            check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("data", 32'(packaged_data), 32'(e.d));
                check("last", 32'(packaged_data_last), 32'(e.last));
                check("frame_error", 32'(frame_error), 32'(e.err));
            end
        end
    end

    initial begin
        byte_q_t p;
        int v0;
        reset_n = 1'b0;
        link_is_10_megabit = 1'b0;
        data = '0;
        data_enable = 1'b0;
        data_error = 1'b0;
        #1;
        idle(3);
        reset_n = 1'b1;
        idle(2);
        @(negedge clock);
        check("rst_data", 32'(packaged_data), 32'd0);
        check("rst_valid", 32'(packaged_data_valid), 32'd0);
        check("rst_last", 32'(packaged_data_last), 32'd0);
        check("rst_err", 32'(frame_error), 32'd0);
        check("rst_speed", 32'(speed_code), 32'd1);

        // Gigabit 64-byte frame.
        p = {};
        for (int i = 1; i <= 64; i++) p.push_back(8'(i));
        model_frame(p, 1'b0);
        v0 = n_valid;
        send_frame(1'b0, 7, 8'hD5, p, -1, 1'b0);
        check("gig_count", 32'(n_valid - v0), 32'd64);
        check("gig_first", 32'(first_data), 32'h101);
        check("gig_last", 32'(last_data), 32'h040);
        check("gig_err", 32'(last_err), 32'(FCS_EN));
        check("gig_speed", 32'(speed_code), 32'd2);
        check("gig_first_latency", 32'(first_cyc - first_drive_cyc), 32'd3);
        check("gig_last_latency", 32'(last_cyc - low_cyc), 32'd2);

        // Nibble mode, 100M then 10M.
        for (int s = 0; s < 2; s++) begin
            link_is_10_megabit = (s == 1);
            p = {8'h34, 8'hA5, 8'h0F};
            model_frame(p, 1'b0);
            v0 = n_valid;
            send_frame(1'b1, 14, 8'hDD, p, -1, 1'b0);
            check("nib_count", 32'(n_valid - v0), 32'd3);
            check("nib_first", 32'(first_data), 32'h134);
            check("nib_last", 32'(last_data), 32'h00F);
            check("nib_speed", 32'(speed_code), (s == 1) ? 32'd0 : 32'd1);
        end
        link_is_10_megabit = 1'b0;

        // Short preamble is ignored; the next frame is received.
        p = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        v0 = n_valid;
        send_frame(1'b0, 3, 8'hD5, p, -1, 1'b0);
        check("short_pre_count", 32'(n_valid - v0), 32'd0);
        p = {};
        for (int i = 0; i < 10; i++) p.push_back(8'(8'hA0 + i));
        model_frame(p, 1'b0);
        v0 = n_valid;
        send_frame(1'b0, 7, 8'hD5, p, -1, 1'b0);
        check("after_short_count", 32'(n_valid - v0), 32'd10);
        check("after_short_speed", 32'(speed_code), 32'd2);

        // RX_ER mid-payload.
        p = {};
        for (int i = 0; i < 20; i++) p.push_back(8'(i * 3 + 2));
        model_frame(p, 1'b1);
        v0 = n_valid;
        send_frame(1'b0, 7, 8'hD5, p, 7, 1'b0);
        check("rxer_count", 32'(n_valid - v0), 32'd20);
        check("rxer_err", 32'(last_err), 32'd1);

        // Odd nibble count: dangling nibble dropped, last byte flagged.
        p = {8'h12, 8'h34};
        model_frame(p, 1'b1);
        v0 = n_valid;
        send_frame(1'b1, 8, 8'hDD, p, -1, 1'b1);
        check("odd_count", 32'(n_valid - v0), 32'd2);
        check("odd_last", 32'(last_data), 32'h034);
        check("odd_err", 32'(last_err), 32'd1);

        // Oversize frame truncated at MAX, then a clean frame.
        p = {};
        for (int i = 1; i <= 100; i++) p.push_back(8'(i));
        model_frame(p, 1'b0);
        v0 = n_valid;
        send_frame(1'b0, 7, 8'hD5, p, -1, 1'b0);
        check("over_count", 32'(n_valid - v0), 32'd64);
        check("over_last", 32'(last_data), 32'h040);
        check("over_err", 32'(last_err), 32'd1);
        p = {};
        for (int i = 0; i < 8; i++) p.push_back(8'(8'h10 + i));
        model_frame(p, 1'b0);
        v0 = n_valid;
        send_frame(1'b0, 7, 8'hD5, p, -1, 1'b0);
        check("post_over_count", 32'(n_valid - v0), 32'd8);
        check("post_over_err", 32'(last_err), 32'(FCS_EN));

        // Reset mid-frame: only bytes already through the 3-cycle pipeline appear.
        v0 = n_valid;
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int k = 0; k < 8; k++) exp_q.push_back('{d: {(k == 0), 8'(8'h20 + k)}, last: 1'b0, err: 1'b0});
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(8'h20 + i));
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 8'h2A);
        reset_n = 1'b1;
        @(negedge clock);
        check("mid_rst_data", 32'(packaged_data), 32'd0);
        check("mid_rst_valid", 32'(packaged_data_valid), 32'd0);
        check("mid_rst_last", 32'(packaged_data_last), 32'd0);
        check("mid_rst_err", 32'(frame_error), 32'd0);
        check("mid_rst_speed", 32'(speed_code), 32'd1);
        for (int i = 11; i < 30; i++) drive(1'b1, 1'b0, 8'(8'h20 + i));
        idle(12);
        check("mid_rst_count", 32'(n_valid - v0), 32'd8);
        p = {8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        model_frame(p, 1'b0);
        v0 = n_valid;
        send_frame(1'b0, 7, 8'hD5, p, -1, 1'b0);
        check("post_rst_count", 32'(n_valid - v0), 32'd6);
        check("post_rst_first", 32'(first_data), 32'h161);

`ifdef RGMII_FRAME_PACKAGER_FCS_CHECK_EN
        // Correct FCS, then a single flipped payload bit.
        begin
            logic [31:0] f;
            p = {};
            for (int i = 0; i < 12; i++) p.push_back(8'(8'h30 + 7 * i));
            f = crc_of(p, 12);
            p.push_back(f[7:0]);
            p.push_back(f[15:8]);
            p.push_back(f[23:16]);
            p.push_back(f[31:24]);
            model_frame(p, 1'b0);
            send_frame(1'b0, 7, 8'hD5, p, -1, 1'b0);
            check("fcs_good_err", 32'(last_err), 32'd0);
            p[3] = p[3] ^ 8'h01;
            model_frame(p, 1'b0);
            send_frame(1'b0, 7, 8'hD5, p, -1, 1'b0);
            check("fcs_bad_err", 32'(last_err), 32'd1);
        end
`endif

        idle(4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgmii_frame_packager.md
Name: rgmii_frame_packager

Overview:
Next-generation RGMII receive packager. Consumes the DDR-captured byte stream from the RGMII input stage, locks on the preamble and SFD, and detects gigabit (byte) versus 10/100 (nibble) mode from the SFD pattern. In nibble mode it reassembles bytes from nibbles. It emits payload bytes with first and last markers plus per-frame error status to the switch ingress FIFO.

Parameters:
PREAMBLE_MIN_BYTES, 6, minimum consecutive 0x55 samples required before an SFD is accepted (1..255).
MAX_FRAME_BYTES, 1522, maximum payload bytes per frame; larger frames are truncated and flagged.
SPEED_CODE_GIGABIT, 2, speed_code value for byte mode.
SPEED_CODE_100_MEGABIT, 1, speed_code value for nibble mode when link_is_10_megabit=0.
SPEED_CODE_10_MEGABIT, 0, speed_code value for nibble mode when link_is_10_megabit=1.

Ports:
clock  in  1  RGMII receive clock; the block's only clock.
reset_n  in  1  synchronous, active-low reset.
data  in  8  captured RGMII byte; in nibble mode [3:0] and [7:4] carry the same nibble.
data_enable  in  1  RX_DV.
data_error  in  1  RX_ER, decoded.
link_is_10_megabit  in  1  PHY status from MDIO; selects between the 10M and 100M speed code in nibble mode.
packaged_data  out  9  [8] = first byte of frame, [7:0] = payload byte.
packaged_data_valid  out  1  one-cycle qualifier for packaged_data.
packaged_data_last  out  1  marks the final byte of the frame; valid only with packaged_data_valid.
frame_error  out  1  asserted with packaged_data_last when the frame had RX_ER, an odd nibble count, oversize, or (with the option enabled) a bad FCS.
speed_code  out  2  last detected speed.

Behaviour:
- Reset values: packaged_data=0, packaged_data_valid=0, packaged_data_last=0, frame_error=0, speed_code=SPEED_CODE_100_MEGABIT. The state machine goes to S_SYNC, and all counters, the pending byte and its flags clear. A reset mid-frame discards the frame with no partial output.
- Inputs are registered once (data_d, enable_d, error_d). All decisions use the registered copies.
- S_SYNC:
  - Counts enable_d && !error_d && data_d==0x55, saturating at 255.
  - Any other sample clears the count, except the following SFD cases, which apply when count >= PREAMBLE_MIN_BYTES:
    - data_d==0xD5 → S_BYTE; speed_code <= SPEED_CODE_GIGABIT.
    - data_d==0xDD → S_NIBBLE_LO; speed_code <= 10M or 100M code per link_is_10_megabit.
  - An SFD seen with count below the minimum clears the count and stays in S_SYNC.
- S_BYTE: each enable_d cycle yields one byte.
- S_NIBBLE_LO / S_NIBBLE_HI:
  - LO latches data_d[3:0]. HI forms the byte {data_d[3:0], lo}.
  - The state toggles on each enable_d cycle.
- Pending stage: each new byte goes into a one-entry pending register.
  - The previous pending byte is output (valid=1, last=0) when a new byte arrives.
  - When enable_d falls in a frame state, the pending byte is output with last=1 and frame_error per the sticky error flag. The state returns to S_SYNC with the count cleared.
  - bit[8]=1 on the first byte output of each frame, 0 otherwise.
- Latency:
  - Gigabit, continuous data: byte presented at cycle t appears at t+3.
  - The last byte appears 2 cycles after data_enable is first low at the input.
- Errors, all via a sticky flag cleared at frame start:
  - error_d during a frame.
  - enable_d falling in S_NIBBLE_HI (odd nibble); the dangling nibble is dropped.
  - Byte count exceeding MAX_FRAME_BYTES: the byte at count MAX_FRAME_BYTES is emitted as last with frame_error=1. The state then goes to S_DROP, which discards input until enable_d is low, then returns to S_SYNC.
- Zero-payload frame (enable falls right after the SFD): no output and no error.
- The byte counter is 16 bits wide and saturates.
- packaged_data_valid asserts for at most 1 cycle per byte. There is no backpressure; the downstream side must accept every valid.

Optional Feature:
RGMII_FRAME_PACKAGER_FCS_CHECK_EN:
- Enabled: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over all payload bytes including the FCS. A residue other than 0xC704DD7B at end of frame sets frame_error on the last byte. Frames shorter than 4 bytes are flagged.
- Disabled: no CRC logic; frame_error reflects only RX_ER, odd nibble and oversize.

Decomposition:
- Package rgmii_pkg: speed code constants, PREAMBLE_BYTE=0x55, SFD_GIGABIT=0xD5, SFD_NIBBLE=0xDD, the state_type enum (S_SYNC, S_BYTE, S_NIBBLE_LO, S_NIBBLE_HI, S_DROP), and CRC constants.
- Sub-module rgmii_crc32_byte: combinational next-CRC from crc+byte, instantiated only under the macro.

Test Plan:
- Gigabit: 7×0x55, 0xD5, payload 0x01..0x40 (64 bytes), enable low → 64 valids, first={1,0x01}, last on 0x40, frame_error=0, speed_code=2, first valid 3 cycles after 0x01 presented.
- Nibble mode, link_is_10_megabit=0: 14×0x55, 0xDD, nibble pairs 0x44,0x33 → byte 0x34, speed_code=1. Repeat with link_is_10_megabit=1 → speed_code=0.
- Short preamble: 3×0x55, 0xD5, data → no output. A following valid frame is received correctly.
- RX_ER asserted for one cycle mid-payload of a 20-byte frame → 20 valids, frame_error=1 on last only. Odd nibble count in nibble mode → last byte flagged, dangling nibble dropped.
- MAX_FRAME_BYTES=64, 100-byte frame → exactly 64 valids, last on byte 64 with frame_error=1. Next frame clean.
- reset_n low for 1 cycle mid-frame → no further valids from that frame. Outputs at reset values. The next frame is received normally. With FCS enabled: a frame with correct FCS gives no error; flipping one payload bit gives frame_error=1.
